// File: rtl/rsa_modexp_engine.sv
// rsa_modexp_engine: result = base^exponent mod modulus.
// Right-to-left square-and-multiply; each product is reduced by a bit-serial
// restoring divider, so latency is fixed at 2 + 2W + W*(4W+2) cycles.
// Optional macro RSA_MODEXP_CYCLE_COUNT_EN adds a saturating cycle_count output.
module rsa_modexp_engine #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             finished
`ifdef RSA_MODEXP_CYCLE_COUNT_EN
  ,
  output logic [15:0]      cycle_count
`endif
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(PW + 1);
  localparam int unsigned IW = $clog2(WIDTH);

  // RBASE: count 0 loads the operand, counts 1..PW are reduction steps.
  localparam logic [CW-1:0] RbaseLast = CW'(PW);
  localparam logic [CW-1:0] RedLast   = CW'(PW - 1);
  localparam logic [IW-1:0] IterLast  = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRbase,
    StMulr,
    StRedr,
    StMulb,
    StRedb,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] base_q, exp_q, mod_q;
  logic [WIDTH-1:0] r_q, b_q, rem_q;
  logic [PW-1:0]    prod_q;
  logic [CW-1:0]    cnt_q;
  logic [IW-1:0]    iter_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q, finished_q;

  logic             accept;
  logic             red_last;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] rem_step;
  logic [PW-1:0]    prod_rb, prod_bb;

  assign accept   = start && !busy_q && ((state_q == StIdle) || (state_q == StDone));
  assign red_last = (cnt_q == RedLast);

  // One restoring-division step. The stored remainder is always < n, so it fits
  // WIDTH bits; the shifted partial remainder needs WIDTH+1.
  always_comb begin
    shifted  = {rem_q, prod_q[PW-1]};
    rem_step = shifted[WIDTH-1:0];
    if (shifted >= {1'b0, mod_q}) begin
      rem_step = shifted[WIDTH-1:0] - mod_q;
    end
  end

  assign prod_rb = {{WIDTH{1'b0}}, r_q} * {{WIDTH{1'b0}}, b_q};
  assign prod_bb = {{WIDTH{1'b0}}, b_q} * {{WIDTH{1'b0}}, b_q};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRbase;
      StRbase: if (cnt_q == RbaseLast) state_d = StMulr;
      StMulr:  state_d = StRedr;
      StRedr:  if (red_last) state_d = StMulb;
      StMulb:  state_d = StRedb;
      StRedb:  if (red_last) state_d = (iter_q == IterLast) ? StDone : StMulr;
      StDone:  if (accept) state_d = StRbase;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: operand latch, square-and-multiply registers and the reducer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q     <= '0;
      exp_q      <= '0;
      mod_q      <= '0;
      r_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      iter_q     <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            base_q     <= base;
            exp_q      <= exponent;
            mod_q      <= modulus;
            cnt_q      <= '0;
            iter_q     <= '0;
            busy_q     <= 1'b1;
            finished_q <= 1'b0;
          end else if (state_q == StDone && busy_q) begin
            // Degenerate moduli override whatever the arithmetic produced.
            result_q   <= (mod_q < WIDTH'(2)) ? '0 : r_q;
            busy_q     <= 1'b0;
            finished_q <= 1'b1;
          end
        end
        StRbase: begin
          if (cnt_q == '0) begin
            prod_q <= {{WIDTH{1'b0}}, base_q};
            rem_q  <= '0;
            r_q    <= WIDTH'(1);
            cnt_q  <= cnt_q + 1'b1;
          end else begin
            rem_q  <= rem_step;
            prod_q <= prod_q << 1;
            if (cnt_q == RbaseLast) begin
              b_q   <= rem_step;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StMulr: begin
          prod_q <= prod_rb;
          rem_q  <= '0;
          cnt_q  <= '0;
        end
        StRedr: begin
          rem_q  <= rem_step;
          prod_q <= prod_q << 1;
          if (red_last) begin
            if (exp_q[0]) r_q <= rem_step;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StMulb: begin
          prod_q <= prod_bb;
          rem_q  <= '0;
          cnt_q  <= '0;
        end
        StRedb: begin
          rem_q  <= rem_step;
          prod_q <= prod_q << 1;
          if (red_last) begin
            b_q    <= rem_step;
            exp_q  <= exp_q >> 1;
            iter_q <= iter_q + 1'b1;
            cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result   = result_q;
  assign busy     = busy_q;
  assign finished = finished_q;

`ifdef RSA_MODEXP_CYCLE_COUNT_EN
  logic [15:0] cyc_q;

  // Saturating busy-cycle counter, cleared on each accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
    end else if (accept) begin
      cyc_q <= '0;
    end else if (busy_q && cyc_q != 16'hFFFF) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end

  assign cycle_count = cyc_q;
`endif

endmodule

// File: doc/rsa_modexp_engine.md
Name: rsa_modexp_engine

Overview:
- Sequential modular-exponentiation core: result = base^exponent mod modulus.
- Consumer of the key generator's outputs: encrypts with (e, n) and decrypts with (d, n).
- Right-to-left square-and-multiply; every modular product is reduced by a bit-serial restoring divider.
- Fixed, data-independent latency; start/finished level handshake, same style as the key generator.

Parameters:
- WIDTH, 16, bit width of base, exponent, modulus and result; the product path is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- base  input  WIDTH  message or ciphertext
- exponent  input  WIDTH  e (encrypt) or d (decrypt)
- modulus  input  WIDTH  n
- result  output  WIDTH  base^exponent mod modulus; valid while finished=1
- busy  output  1  computation in progress
- finished  output  1  result valid; level, held until next accepted start

Behaviour:
- Reset (async, any state): state=IDLE; result=0, busy=0, finished=0; all internal registers cleared.
- Start acceptance:
  - Accepted on a clk edge with start=1 and busy=0, in IDLE or DONE.
  - On that edge: latch base/exponent/modulus; busy<=1, finished<=0; go to RBASE.
  - start while busy=1 is ignored; the latched operands do not change.
- States: IDLE -> RBASE -> (MULR -> REDR -> MULB -> REDB) x WIDTH -> DONE.
- RBASE:
  - b = {0, base} mod n, using the reducer.
  - r initialised to 1.
- MULR (1 cycle): P = r*b, full 2*WIDTH bits, no truncation.
- REDR: reduce P by n. Commit r <= P mod n only if exponent bit i is 1; otherwise r is unchanged.
- MULB (1 cycle): P = b*b.
- REDB: b <= P mod n. Then shift the exponent right and increment i.
  - After iteration WIDTH-1, go to DONE.
  - All WIDTH iterations always run (constant latency, no early exit on leading zeros).
- Reducer (restoring, 2*WIDTH cycles):
  - rem is WIDTH+1 bits, starts at 0.
  - Each cycle, for bit k from 2*WIDTH-1 down to 0: rem = (rem<<1)|P[k]; if rem >= n then rem -= n.
  - Final rem < n.
- DONE:
  - result <= r, forced to 0 when modulus < 2; this overrides the arithmetic path.
  - busy<=0, finished<=1. Stay in DONE until start.
- Latency: finished rises exactly L = 2 + 2W + W*(4W+2) cycles after the accepting edge. W=16 gives L=1090.
- Boundary values:
  - exponent=0 with modulus>=2 gives 1.
  - base=0 with exponent>0 gives 0.
  - base >= modulus is reduced first.
  - modulus = 0 or 1 gives result 0 after the full L cycles.
- Back-to-back: start held high in DONE is accepted on the next edge. finished drops the cycle after acceptance, and result keeps its old value until the new DONE.

Optional Feature:
- Macro: RSA_MODEXP_CYCLE_COUNT_EN.
- Defined:
  - Adds output cycle_count [15:0], reset 0.
  - Cleared on the accepting edge and incremented every cycle while busy=1; saturates at 16'hFFFF.
  - Holds its value in DONE, so it reads L when finished=1 (1090 for W=16).
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Encrypt: base=65, exponent=17, modulus=3233, pulse start -> finished=1 exactly 1090 cycles later, result=2790, busy=0.
- Decrypt: base=2790, exponent=2753, modulus=3233 -> result=65. Bench also chains with the key generator (p=61, q=53, e=17) and checks a round trip.
- Edges:
  - base=5, exponent=0, modulus=7 -> 1.
  - base=10, exponent=1, modulus=7 -> 3.
  - base=0, exponent=9, modulus=7 -> 0.
  - modulus=1 and modulus=0 -> 0 after 1090 cycles.
- Max operands: base=65535, exponent=65535, modulus=65521 -> result=18532.
- Handshake:
  - start re-pulsed with new operands at cycle 300 -> ignored; original result returned.
  - rst asserted at cycle 500 -> result/busy/finished=0 immediately (async).
  - New start after reset completes correctly.
- Macro build: cycle_count=1090 at finished. Start held high through DONE -> restart next cycle and cycle_count restarts from 0.
